// File: rtl/sqrt_sched.sv
// sqrt_sched: round-robin front end that time-shares one iterative sqrt core among N_REQ requesters.
// Optional macro SQRT_SCHED_DONE_CHECK_EN: early completion on core_cstate==DONE_STATE, res_err on timeout.
module sqrt_sched #(
    parameter int         N_REQ      = 4,
    parameter int         TAG_W      = 2,
    parameter int         DIN_W      = 32,
    parameter int         DOUT_W     = 16,
    parameter int         CORE_LAT   = 18,
    parameter logic [3:0] DONE_STATE = 4'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*DIN_W-1:0] req_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DOUT_W-1:0]      res_data,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   res_err,
    output logic                   busy,
    output logic                   core_reset,
    output logic [DIN_W-1:0]       core_din,
    input  logic [DOUT_W-1:0]      core_dout,
    input  logic [3:0]             core_cstate
);
    localparam int              CNT_W    = $clog2(CORE_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                res_valid_q, res_valid_d;
    logic [DOUT_W-1:0]   res_data_q, res_data_d;
    logic [TAG_W-1:0]    res_tag_q, res_tag_d;
    logic                res_err_q, res_err_d;
    logic [DIN_W-1:0]    core_din_q, core_din_d;

    logic [N_REQ-1:0]    grant_s;
    logic [TAG_W-1:0]    grant_idx_s;
    logic [TAG_W-1:0]    scan_idx_s;
    logic                grant_any_s;

`ifndef SQRT_SCHED_DONE_CHECK_EN
    logic unused_cstate_s;
    assign unused_cstate_s = ^{core_cstate, DONE_STATE};
`endif

    // Round-robin grant: scan from rr_ptr downwards in priority so the closest requester wins last.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        scan_idx_s  = '0;
        grant_any_s = 1'b0;
        if ((state_q == ST_IDLE) && !reset) begin
            grant_any_s = |req_valid;
            for (int k = N_REQ - 1; k >= 0; k--) begin
                scan_idx_s  = rr_ptr_q + TAG_W'(k);
                grant_idx_s = req_valid[scan_idx_s] ? scan_idx_s : grant_idx_s;
            end
            grant_s[grant_idx_s] = grant_any_s;
        end else begin
            grant_s = '0;
        end
    end

    // Next-state, operand/result capture and pointer update.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_err_d   = res_err_q;
        core_din_d  = core_din_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_any_s) begin
                    core_din_d = req_data[int'(grant_idx_s) * DIN_W +: DIN_W];
                    res_tag_d  = grant_idx_s;
                    rr_ptr_d   = grant_idx_s + TAG_W'(1);
                    state_d    = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                cnt_d     = '0;
                res_err_d = 1'b0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef SQRT_SCHED_DONE_CHECK_EN
                if ((core_cstate == DONE_STATE) && (cnt_q != '0)) begin
                    res_data_d  = core_dout;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    res_data_d  = core_dout;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                if (cnt_q == CNT_LAST) begin
                    res_data_d  = core_dout;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_err_q   <= 1'b0;
            core_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_err_q   <= res_err_d;
            core_din_q  <= core_din_d;
        end
    end

    assign req_ready  = grant_s;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_tag    = res_tag_q;
    assign res_err    = res_err_q;
    assign core_din   = core_din_q;
    assign busy       = (state_q != ST_IDLE);
    assign core_reset = reset | (state_q == ST_LAUNCH);

endmodule

// File: tb/tb_sqrt_sched.sv
// Bench for sqrt_sched: behavioural sqrt core, transaction-level scheduler model and directed tests.
module tb_sqrt_sched;
    localparam int N_REQ    = 4;
    localparam int TAG_W    = 2;
    localparam int DIN_W    = 32;
    localparam int DOUT_W   = 16;
    localparam int CORE_LAT = 18;
`ifdef SQRT_SCHED_DONE_CHECK_EN
    localparam bit DONE_CHK = 1'b1;
`else
    localparam bit DONE_CHK = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*DIN_W-1:0] req_data;
    logic                   res_valid;
    logic                   res_ready;
    logic [DOUT_W-1:0]      res_data;
    logic [TAG_W-1:0]       res_tag;
    logic                   res_err;
    logic                   busy;
    logic                   core_reset;
    logic [DIN_W-1:0]       core_din;
    logic [DOUT_W-1:0]      core_dout;
    logic [3:0]             core_cstate;

    always #5 clk = ~clk;

    sqrt_sched #(
        .N_REQ(N_REQ), .TAG_W(TAG_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W),
        .CORE_LAT(CORE_LAT), .DONE_STATE(4'd0)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_tag(res_tag), .res_err(res_err), .busy(busy),
        .core_reset(core_reset), .core_din(core_din), .core_dout(core_dout),
        .core_cstate(core_cstate)
    );

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        longint r, t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return r[15:0];
    endfunction

    // Sqrt core: output is garbage until its latency has elapsed since reset release.
    int core_cyc = 0;
    int done_at  = -1;
    always @(posedge clk) begin
        if (core_reset) core_cyc <= 0;
        else if (core_cyc < 1000) core_cyc <= core_cyc + 1;
    end
    assign core_dout = (core_cyc >= CORE_LAT - 1 || (done_at >= 1 && core_cyc >= done_at))
                       ? isqrt(core_din) : (16'hBAD0 ^ 16'(core_cyc));
    assign core_cstate = (done_at >= 1 && core_cyc == done_at) ? 4'd0 : 4'd9;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int rr, input logic [N_REQ-1:0] v);
        for (int k = 0; k < N_REQ; k++)
            if (v[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
        return -1;
    endfunction

    // Model state: 0 idle, 1 launch, 2 wait, 3 hold
    int          m_st = 0, m_rr = 0, m_k = 0, m_tag = 0;
    logic [31:0] m_op = '0;
    logic [15:0] m_res = '0;
    bit          m_err = 1'b0;
    int          cyc_n = 0;
    bit          prev_valid = 1'b0;
    int          acc_cyc[$];
    logic [3:0]  acc_vec[$];
    int          rise_cyc[$];
    int          hs_cyc[$];
    logic [15:0] hs_data[$];
    logic [1:0]  hs_tag[$];
    bit          hs_err[$];

    // Compare DUT against the model each cycle, log events, then advance the model.
    always @(negedge clk) begin
        int g;
        logic [N_REQ-1:0] exp_rdy;
        cyc_n++;
        if (reset) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_core_reset", core_reset, 1);
            chk("rst_res_data", res_data, 0);
            chk("rst_res_tag", res_tag, 0);
            chk("rst_res_err", res_err, 0);
            chk("rst_core_din", core_din, 0);
            m_st = 0; m_rr = 0; m_op = '0; m_res = '0; m_tag = 0; m_err = 1'b0;
            prev_valid = 1'b0;
        end else begin
            g = (m_st == 0) ? pick(m_rr, req_valid) : -1;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, m_st != 0);
            chk("core_reset", core_reset, m_st == 1);
            chk("core_din", core_din, m_op);
            chk("res_valid", res_valid, m_st == 3);
            chk("res_data", res_data, m_res);
            chk("res_tag", res_tag, m_tag);
            chk("res_err", res_err, m_err);
            if (|req_ready) begin acc_cyc.push_back(cyc_n); acc_vec.push_back(req_ready); end
            if (res_valid && !prev_valid) rise_cyc.push_back(cyc_n);
            if (res_valid && res_ready) begin
                hs_cyc.push_back(cyc_n); hs_data.push_back(res_data);
                hs_tag.push_back(res_tag); hs_err.push_back(res_err);
            end
            prev_valid = res_valid;
            case (m_st)
                0: if (g >= 0) begin
                    m_tag = g; m_op = req_data[g*DIN_W +: DIN_W];
                    m_rr = (g + 1) % N_REQ; m_st = 1;
                end
                1: begin m_st = 2; m_k = 0; m_err = 1'b0; end
                2: if (DONE_CHK && done_at >= 1 && m_k == done_at) begin
                    m_res = isqrt(m_op); m_err = 1'b0; m_st = 3;
                end else if (m_k == CORE_LAT - 1) begin
                    m_res = isqrt(m_op); m_err = DONE_CHK; m_st = 3;
                end else begin
                    m_k++;
                end
                default: if (res_ready) m_st = 0;
            endcase
        end
    end

    task automatic set_op(input int i, input logic [31:0] v);
        req_data[i*DIN_W +: DIN_W] = v;
    endtask

    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 300 && !ok; t++) begin @(negedge clk); ok = |req_ready; end
        chk({name, "_accept_timeout"}, ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_hs(input int n, input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 1000 && !ok; t++) begin @(negedge clk); ok = (hs_data.size() >= n); end
        chk({name, "_result_timeout"}, ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ba, br, bh;
        logic [15:0] exp_d [5];
        logic [1:0]  exp_t [5];
        bit ok;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;

        chk("model_isqrt_999", isqrt(32'd999), 31);
        chk("model_isqrt_65535", isqrt(32'd65535), 255);
        chk("model_isqrt_max", isqrt(32'hFFFF_FFFF), 65535);
        chk("model_isqrt_1e6", isqrt(32'd1000000), 1000);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single request, latency and value
        ba = acc_cyc.size(); br = rise_cyc.size(); bh = hs_data.size();
        set_op(0, 32'd999);
        req_valid = 4'b0001;
        wait_accept("t1");
        req_valid = 4'b0000;
        wait_hs(bh + 1, "t1");
        chk("t1_grant", acc_vec[ba], 4'b0001);
        chk("t1_latency", rise_cyc[br] - acc_cyc[ba], CORE_LAT + 2);
        chk("t1_data", hs_data[bh], 31);
        chk("t1_tag", hs_tag[bh], 0);

        // All four requesting continuously
        do_reset(2);
        set_op(0, 32'd0); set_op(1, 32'd1); set_op(2, 32'd65535); set_op(3, 32'hFFFF_FFFF);
        ba = acc_cyc.size(); br = rise_cyc.size(); bh = hs_data.size();
        req_valid = 4'b1111;
        repeat (5) wait_accept("t2");
        req_valid = 4'b0000;
        wait_hs(bh + 5, "t2");
        exp_t = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_d = '{16'd0, 16'd1, 16'd255, 16'd65535, 16'd0};
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_tag%0d", i), hs_tag[bh+i], exp_t[i]);
            chk($sformatf("t2_data%0d", i), hs_data[bh+i], exp_d[i]);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_spacing%0d", i), rise_cyc[br+i+1] - rise_cyc[br+i], CORE_LAT + 3);

        // Back-pressure in HOLD; late operand change has no effect
        res_ready = 1'b0;
        set_op(1, 32'd144);
        bh = hs_data.size();
        req_valid = 4'b0010;
        wait_accept("t3");
        req_valid = 4'b1111;
        set_op(1, 32'd7);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin @(negedge clk); ok = res_valid; end
        chk("t3_hold_timeout", ok, 1);
        repeat (10) @(posedge clk);
        #1;
        ba = acc_cyc.size();
        res_ready = 1'b1;
        wait_accept("t3b");
        req_valid = 4'b0000;
        wait_hs(bh + 2, "t3");
        chk("t3_data", hs_data[bh], 12);
        chk("t3_tag", hs_tag[bh], 1);
        chk("t3_next_grant", acc_vec[ba], 4'b0100);
        chk("t3_grant_gap", acc_cyc[ba] - hs_cyc[bh], 1);

        // Bring rr_ptr to 2, then requests from 0 and 3 only
        set_op(1, 32'd4);
        bh = hs_data.size();
        req_valid = 4'b0010;
        wait_accept("t4a");
        req_valid = 4'b0000;
        wait_hs(bh + 1, "t4a");
        set_op(0, 32'd16); set_op(3, 32'd81);
        ba = acc_cyc.size(); bh = hs_data.size();
        req_valid = 4'b1001;
        wait_accept("t4");
        wait_accept("t4");
        req_valid = 4'b0000;
        wait_hs(bh + 2, "t4");
        chk("t4_grant0", acc_vec[ba], 4'b1000);
        chk("t4_grant1", acc_vec[ba+1], 4'b0001);
        chk("t4_data0", hs_data[bh], 9);
        chk("t4_data1", hs_data[bh+1], 4);

        // Reset during WAIT at cnt=5
        set_op(2, 32'd10000);
        br = rise_cyc.size(); bh = hs_data.size();
        req_valid = 4'b0100;
        wait_accept("t5");
        req_valid = 4'b0000;
        repeat (6) @(posedge clk);
        #1;
        do_reset(2);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_result", rise_cyc.size(), br);
        set_op(0, 32'd1000000); set_op(1, 32'd5);
        ba = acc_cyc.size();
        req_valid = 4'b0011;
        wait_accept("t5b");
        req_valid = 4'b0000;
        wait_hs(bh + 1, "t5b");
        chk("t5_rr_reset_grant", acc_vec[ba], 4'b0001);
        chk("t5_data", hs_data[bh], 1000);
        chk("t5_tag", hs_tag[bh], 0);

`ifdef SQRT_SCHED_DONE_CHECK_EN
        // Early completion on DONE_STATE, then timeout error
        done_at = 7;
        set_op(3, 32'd50);
        ba = acc_cyc.size(); br = rise_cyc.size(); bh = hs_data.size();
        req_valid = 4'b1000;
        wait_accept("t6");
        req_valid = 4'b0000;
        wait_hs(bh + 1, "t6");
        chk("t6_early_latency", rise_cyc[br] - acc_cyc[ba], 10);
        chk("t6_data", hs_data[bh], 7);
        chk("t6_err", hs_err[bh], 0);
        done_at = -1;
        ba = acc_cyc.size(); br = rise_cyc.size(); bh = hs_data.size();
        req_valid = 4'b1000;
        wait_accept("t6b");
        req_valid = 4'b0000;
        wait_hs(bh + 1, "t6b");
        chk("t6_timeout_latency", rise_cyc[br] - acc_cyc[ba], CORE_LAT + 2);
        chk("t6_timeout_err", hs_err[bh], 1);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sqrt_sched.md
Name: sqrt_sched

Overview:
Round-robin scheduler that shares one iterative sqrt core (clk/reset/din/dout/cstate interface) among N_REQ requesters, e.g. per-channel envelope magnitude (I²+Q²) sources.
- Arbitrates requests and launches the core by pulsing its reset with the operand held on din.
- Waits the core latency, captures dout, and returns the result tagged with the requester index over a valid/ready channel.
- Sits between the beamformer/envelope stage and the shared sqrt datapath.

Parameters:
N_REQ, 4, number of requesters (power of 2, ≥2)
TAG_W, 2, requester index width (log2 N_REQ)
DIN_W, 32, operand width
DOUT_W, 16, result width (DIN_W/2)
CORE_LAT, 18, cycles from core reset release to valid core_dout
DONE_STATE, 4'd0, core cstate value meaning "result ready" (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero
req_data  in  N_REQ*DIN_W  operands; requester i occupies bits [i*DIN_W +: DIN_W]
res_valid  out  1  result valid
res_ready  in  1  result accept
res_data  out  DOUT_W  floor(sqrt(operand))
res_tag  out  TAG_W  index of the requester that owns res_data
res_err  out  1  completion error flag (0 unless feature enabled)
busy  out  1  high whenever state != IDLE
core_reset  out  1  drives sqrt core reset
core_din  out  DIN_W  drives sqrt core din
core_dout  in  DOUT_W  sqrt core dout
core_cstate  in  4  sqrt core cstate

Behaviour:
- Reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, cnt=0, res_valid=0, res_data=0, res_tag=0, res_err=0, core_din=0.
  - core_reset=1 (core_reset = reset OR launch_pulse).
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE:
  - req_ready combinational: one-hot grant to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo N_REQ.
  - All req_ready bits are 0 outside IDLE.
  - On accept (edge E0): latch core_din=req_data[i], res_tag=i, rr_ptr=(i+1) mod N_REQ, go to LAUNCH.
  - No valid request: stay in IDLE, rr_ptr unchanged.
- LAUNCH: exactly one cycle; core_reset=1; cnt=0; next state WAIT.
- WAIT:
  - core_reset=0; cnt increments each cycle.
  - When cnt==CORE_LAT-1: res_data<=core_dout, res_valid<=1, go to HOLD.
- HOLD:
  - res_valid=1; res_data, res_tag and res_err remain stable.
  - On res_valid&&res_ready: res_valid<=0, go to IDLE.
  - New grants are issued no earlier than the following cycle (no IDLE bypass).
- Latency: res_valid rises CORE_LAT+2 cycles after accept edge E0.
- Throughput: one operation per CORE_LAT+3 cycles when res_ready=1.
- core_din is stable from LAUNCH through the end of WAIT.
- Requester changes to req_data/req_valid after acceptance have no effect.
- Fairness:
  - A continuously asserted requester is served within N_REQ operations.
  - A requester dropping req_valid before its grant loses nothing; it is simply skipped.
- Reset mid-operation (any state):
  - Immediate return to reset values; the in-flight operation is discarded.
  - No res_valid is issued for it.
  - core_reset asserts with reset.
- res_err reflects only the current result; it is cleared on each LAUNCH.

Optional Feature:
SQRT_SCHED_DONE_CHECK_EN
- Defined:
  - WAIT also exits early on the first cycle core_cstate==DONE_STATE with cnt≥1; res_data captures core_dout that cycle and res_err=0.
  - If cnt reaches CORE_LAT-1 without DONE_STATE, exit as normal with res_err=1.
- Undefined:
  - Fixed CORE_LAT wait, core_cstate ignored, res_err tied 0.

Test Plan:
- Reset held 2 cycles, then req_valid=4'b0001, req_data[0]=999 → req_ready=0001 at E0; core_reset high 1 cycle; res_valid at E0+CORE_LAT+2; res_data=31, res_tag=0.
- All four requesters valid continuously, operands 0, 1, 65535, 0xFFFFFFFF → results in tag order 0,1,2,3,0 with values 0, 1, 255, 65535; spacing CORE_LAT+3 cycles.
- res_ready=0 for 10 cycles in HOLD → res_valid, res_data and res_tag stable; req_ready all 0 throughout; release → IDLE, next grant one cycle later.
- rr_ptr=2 with requests from 0 and 3 only → grant 3 first, then 0.
- Assert reset at WAIT cnt=5 → res_valid never rises, state IDLE, rr_ptr=0, core_reset=1 during reset; next request completes normally.
- With SQRT_SCHED_DONE_CHECK_EN, model core_cstate=DONE_STATE at cnt=7 → result captured at cnt=7, res_err=0; model never reaching DONE_STATE → res_err=1 at CORE_LAT timeout.
